// File: rtl/axis_test_checker_if.sv
// AXI-Stream test-packet bus: 64-bit data, 80-bit tuser {len, mac, type}.
interface axis_test_checker_if;
  logic [63:0] tdata;
  logic [79:0] tuser;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, tuser, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tuser, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_test_checker.sv
// Sink/checker for AXIS test packets: pattern, length, tkeep and tuser checks plus counters.
// Optional macro AXIS_CHK_BACKPRESSURE_EN gates tready with a free-running LFSR.
module axis_test_checker #(
  parameter int unsigned P_INIT_CYCLES = 64,
  parameter logic [47:0] P_EXP_MAC     = 48'h0102_0304_0506,
  parameter logic [15:0] P_EXP_TYPE    = 16'h0800
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  axis_test_checker_if.slave  s_axis,
  output logic [31:0]         o_pkt_cnt,
  output logic [15:0]         o_err_pkt_cnt,
  output logic [15:0]         o_last_bytes,
  output logic                o_pkt_done,
  output logic                o_pkt_err,
  output logic                o_data_err,
  output logic                o_len_err,
  output logic                o_keep_err,
  output logic                o_user_err
);
  localparam int unsigned IDX_W  = 16;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned USER_W = 80;
  localparam int unsigned KEEP_W = 8;
  localparam int unsigned ERR_W  = 4; // {data, len, keep, user}

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_RECV} state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    init_cnt;
  logic [IDX_W-1:0]    beat_idx;
  logic [USER_W-1:0]   r_user;
  logic [ERR_W-1:0]    pkt_acc;

  logic                xfer;
  logic                ready_nxt;
  logic [IDX_W-1:0]    beat_cur;
  logic [IDX_W-1:0]    len_ref;
  logic [DATA_W-1:0]   exp_data;
  logic [DATA_W-1:0]   byte_mask;
  logic [ERR_W-1:0]    beat_err;
  logic [ERR_W-1:0]    fin_err;
  logic [IDX_W-1:0]    last_bytes_nxt;

  function automatic logic keep_last_ok(input logic [KEEP_W-1:0] k);
    case (k)
      8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80: keep_last_ok = 1'b1;
      default:                                                keep_last_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] popcnt8(input logic [KEEP_W-1:0] k);
    popcnt8 = 4'd0;
    for (int i = 0; i < 8; i++) popcnt8 = popcnt8 + 4'(k[i]);
  endfunction

`ifdef AXIS_CHK_BACKPRESSURE_EN
  logic [7:0] lfsr, lfsr_nxt;
  assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  // Free-running stall pattern, x^8+x^6+x^5+x^4+1
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) lfsr <= 8'hA5;
    else          lfsr <= lfsr_nxt;
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_INIT;
    else          state <= state_nxt;
  end

  // Next state plus per-beat check evaluation
  always_comb begin
    state_nxt      = state;
    ready_nxt      = 1'b0;
    xfer           = s_axis.tvalid & s_axis.tready;
    beat_cur       = (state == ST_RECV) ? beat_idx : '0;
    len_ref        = (state == ST_RECV) ? r_user[79:64] : s_axis.tuser[79:64];
    exp_data       = {4{beat_cur}};
    byte_mask      = '0;
    beat_err       = '0;
    fin_err        = '0;
    last_bytes_nxt = '0;

    case (state)
      ST_INIT: if (init_cnt == IDX_W'(P_INIT_CYCLES - 1)) state_nxt = ST_IDLE;
      ST_IDLE: if (xfer && !s_axis.tlast) state_nxt = ST_RECV;
      ST_RECV: if (xfer && s_axis.tlast) state_nxt = ST_IDLE;
      default: state_nxt = ST_INIT;
    endcase

    for (int i = 0; i < 8; i++) byte_mask[8*i +: 8] = {8{s_axis.tkeep[i]}};

    beat_err[3] = |((s_axis.tdata ^ exp_data) & byte_mask);
    beat_err[2] = s_axis.tlast && ((beat_cur + IDX_W'(1)) != len_ref);
    beat_err[1] = s_axis.tlast ? !keep_last_ok(s_axis.tkeep) : (s_axis.tkeep != 8'hFF);
    beat_err[0] = (state == ST_RECV) ? (s_axis.tuser != r_user)
                                     : (s_axis.tuser[63:0] != {P_EXP_MAC, P_EXP_TYPE});
    fin_err        = pkt_acc | beat_err;
    last_bytes_nxt = {beat_cur[12:0], 3'b000} + IDX_W'(popcnt8(s_axis.tkeep));

`ifdef AXIS_CHK_BACKPRESSURE_EN
    ready_nxt = (state_nxt != ST_INIT) & lfsr_nxt[0];
`else
    ready_nxt = (state_nxt != ST_INIT);
`endif
  end

  // Beat tracking, packet finalisation, counters and sticky flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      init_cnt      <= '0;
      beat_idx      <= '0;
      r_user        <= '0;
      pkt_acc       <= '0;
      s_axis.tready <= 1'b0;
      o_pkt_cnt     <= '0;
      o_err_pkt_cnt <= '0;
      o_last_bytes  <= '0;
      o_pkt_done    <= 1'b0;
      o_pkt_err     <= 1'b0;
      o_data_err    <= 1'b0;
      o_len_err     <= 1'b0;
      o_keep_err    <= 1'b0;
      o_user_err    <= 1'b0;
    end else begin
      s_axis.tready <= ready_nxt;
      o_pkt_done    <= 1'b0;
      o_pkt_err     <= 1'b0;
      if (state == ST_INIT) init_cnt <= init_cnt + IDX_W'(1);
      if (xfer) begin
        if (state == ST_IDLE) r_user <= s_axis.tuser;
        beat_idx <= beat_cur + IDX_W'(1);
        if (s_axis.tlast) begin
          pkt_acc      <= '0;
          o_pkt_done   <= 1'b1;
          o_pkt_err    <= |fin_err;
          o_pkt_cnt    <= o_pkt_cnt + 32'd1;
          o_last_bytes <= last_bytes_nxt;
          if ((|fin_err) && (o_err_pkt_cnt != 16'hFFFF))
            o_err_pkt_cnt <= o_err_pkt_cnt + 16'd1;
          o_data_err <= o_data_err | fin_err[3];
          o_len_err  <= o_len_err  | fin_err[2];
          o_keep_err <= o_keep_err | fin_err[1];
          o_user_err <= o_user_err | fin_err[0];
        end else begin
          pkt_acc <= fin_err;
        end
      end
    end
  end
endmodule

// File: tb/tb_axis_test_checker.sv
// Directed self-checking bench for axis_test_checker.
module tb_axis_test_checker;
  localparam logic [47:0] MAC  = 48'h0102_0304_0506;
  localparam logic [15:0] TYPE = 16'h0800;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] o_pkt_cnt;
  logic [15:0] o_err_pkt_cnt, o_last_bytes;
  logic        o_pkt_done, o_pkt_err, o_data_err, o_len_err, o_keep_err, o_user_err;

  int checks = 0;
  int errors = 0;
  logic done, perr;

  always #5 i_clk = ~i_clk;

  axis_test_checker_if bus ();

  axis_test_checker dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .s_axis        (bus),
    .o_pkt_cnt     (o_pkt_cnt),
    .o_err_pkt_cnt (o_err_pkt_cnt),
    .o_last_bytes  (o_last_bytes),
    .o_pkt_done    (o_pkt_done),
    .o_pkt_err     (o_pkt_err),
    .o_data_err    (o_data_err),
    .o_len_err     (o_len_err),
    .o_keep_err    (o_keep_err),
    .o_user_err    (o_user_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, o_data_err, o_len_err, o_keep_err, o_user_err}, {28'd0, exp});
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge i_clk);
    while (!bus.tready && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    if (!bus.tready) chk("ready_timeout", {31'd0, bus.tready}, 32'd1);
  endtask

  task automatic send_pkt(input int nbeats, input int len, input logic [47:0] mac,
                          input logic [7:0] last_keep, input int bad_beat,
                          input logic [63:0] bad_data, input int chg_beat, input int rst_beat,
                          output logic pdone, output logic perr_o);
    logic [15:0] k16;
    pdone  = 1'b0;
    perr_o = 1'b0;
    for (int k = 0; k < nbeats; k++) begin
      k16          = 16'(k);
      bus.tdata    = (k == bad_beat) ? bad_data : {4{k16}};
      bus.tuser    = {16'(len), mac, (chg_beat >= 0 && k >= chg_beat) ? 16'h0806 : TYPE};
      bus.tlast    = (k == nbeats - 1);
      bus.tkeep    = (k == nbeats - 1) ? last_keep : 8'hFF;
      bus.tvalid   = 1'b1;
      if (k == rst_beat) begin
        i_rst_n = 1'b0;
        #1;
        return;
      end
      wait_ready();
      @(posedge i_clk);
      #1;
    end
    bus.tvalid = 1'b0;
    bus.tlast  = 1'b0;
    pdone      = o_pkt_done;
    perr_o     = o_pkt_err;
  endtask

  initial begin
    bus.tdata  = 64'hDEAD_BEEF_CAFE_F00D;
    bus.tuser  = '0;
    bus.tkeep  = 8'hFF;
    bus.tlast  = 1'b1;
    bus.tvalid = 1'b0;
    #23;
    chk("rst_pkt_cnt", o_pkt_cnt, 32'd0);
    chk("rst_tready", {31'd0, bus.tready}, 32'd0);
    chk_flags("rst_flags", 4'b0000);

    // Init window: tvalid held high, tready must stay low for 64 cycles
    bus.tvalid = 1'b1;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      @(posedge i_clk);
      #1;
`ifdef AXIS_CHK_BACKPRESSURE_EN
      if (i < 64) chk($sformatf("init_tready_%0d", i), {31'd0, bus.tready}, 32'd0);
`else
      chk($sformatf("init_tready_%0d", i), {31'd0, bus.tready}, (i == 64) ? 32'd1 : 32'd0);
`endif
      if (i == 64) bus.tvalid = 1'b0;
    end
    chk("init_no_xfer", o_pkt_cnt, 32'd0);

    // Three clean 186-beat packets
    for (int p = 0; p < 3; p++) begin
      send_pkt(186, 186, MAC, 8'hFF, -1, '0, -1, -1, done, perr);
      chk($sformatf("clean%0d_done", p), {30'd0, done, perr}, 32'd2);
    end
    @(posedge i_clk);
    #1;
    chk("done_pulse_clear", {31'd0, o_pkt_done}, 32'd0);
    chk("clean_pkt_cnt", o_pkt_cnt, 32'd3);
    chk("clean_last_bytes", {16'd0, o_last_bytes}, 32'd1488);
    chk("clean_err_cnt", {16'd0, o_err_pkt_cnt}, 32'd0);
    chk_flags("clean_flags", 4'b0000);

    // Partial last beat E0; masked-off low bytes corrupted on purpose
    send_pkt(186, 186, MAC, 8'hE0, 185, 64'h00B9_00B9_00B9_DEAD, -1, -1, done, perr);
    chk("e0_done", {30'd0, done, perr}, 32'd2);
    chk("e0_last_bytes", {16'd0, o_last_bytes}, 32'd1483);
    chk_flags("e0_flags", 4'b0000);

    send_pkt(186, 186, MAC, 8'h0F, -1, '0, -1, -1, done, perr);
    chk("k0f_done", {30'd0, done, perr}, 32'd3);
    chk_flags("k0f_flags", 4'b0010);
    chk("k0f_err_cnt", {16'd0, o_err_pkt_cnt}, 32'd1);
    chk("k0f_last_bytes", {16'd0, o_last_bytes}, 32'd1484);

    // Short packet: 185 beats against len 186
    send_pkt(185, 186, MAC, 8'hFF, -1, '0, -1, -1, done, perr);
    chk("short_done", {30'd0, done, perr}, 32'd3);
    chk_flags("short_flags", 4'b0110);
    chk("short_last_bytes", {16'd0, o_last_bytes}, 32'd1480);
    send_pkt(186, 186, MAC, 8'hFF, -1, '0, -1, -1, done, perr);
    chk("after_short_done", {30'd0, done, perr}, 32'd2);
    chk_flags("after_short_flags", 4'b0110);
    chk("after_short_cnt", o_pkt_cnt, 32'd7);

    // Single-beat packets
    send_pkt(1, 1, MAC, 8'h80, -1, '0, -1, -1, done, perr);
    chk("single_done", {30'd0, done, perr}, 32'd2);
    chk("single_last_bytes", {16'd0, o_last_bytes}, 32'd1);
    send_pkt(1, 1, 48'h0102_0304_0507, 8'hFF, -1, '0, -1, -1, done, perr);
    chk("badmac_done", {30'd0, done, perr}, 32'd3);
    chk_flags("badmac_flags", 4'b0111);
    chk("badmac_last_bytes", {16'd0, o_last_bytes}, 32'd8);

    send_pkt(186, 186, MAC, 8'hFF, 20, 64'h0014_0014_0015_0014, -1, -1, done, perr);
    chk("data_done", {30'd0, done, perr}, 32'd3);
    chk_flags("data_flags", 4'b1111);

    send_pkt(186, 186, MAC, 8'hFF, -1, '0, 30, -1, done, perr);
    chk("user_done", {30'd0, done, perr}, 32'd3);
    chk("user_pkt_cnt", o_pkt_cnt, 32'd11);
    chk("user_err_cnt", {16'd0, o_err_pkt_cnt}, 32'd5);

    // Reset in the middle of a packet
    send_pkt(186, 186, MAC, 8'hFF, -1, '0, -1, 50, done, perr);
    chk("mrst_pkt_cnt", o_pkt_cnt, 32'd0);
    chk("mrst_err_cnt", {16'd0, o_err_pkt_cnt}, 32'd0);
    chk("mrst_last_bytes", {16'd0, o_last_bytes}, 32'd0);
    chk("mrst_ready_done", {30'd0, bus.tready, o_pkt_done}, 32'd0);
    chk_flags("mrst_flags", 4'b0000);
    bus.tvalid = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    send_pkt(186, 186, MAC, 8'hFF, -1, '0, -1, -1, done, perr);
    chk("recover_done", {30'd0, done, perr}, 32'd2);
    chk("recover_pkt_cnt", o_pkt_cnt, 32'd1);
    chk("recover_last_bytes", {16'd0, o_last_bytes}, 32'd1488);
    chk_flags("recover_flags", 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
